// File: rtl/i2s_tdm_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_tdm_transmitter
//   Parametrised I2S / left-justified / right-justified TDM serialiser with an
//   integer bit-clock divider, a one-entry sample holding register fed by a
//   valid/ready handshake, and zero-fill on underrun.
//
// Optional feature macro: I2S_UNDERRUN_CNT_EN
//   When defined, adds underrun_count[15:0], a saturating count of underrun
//   pulses cleared by reset.
//
// Ports:
//   clk_in          system clock, all logic on posedge
//   reset           asynchronous active-high reset
//   sample_data     packed frame, channel n at [n*BITS +: BITS]
//   sample_valid    sample_data valid
//   sample_ready    holding register empty (registered)
//   frame_pulse     1-cycle strobe: holding register moved to frame buffer
//   underrun        1-cycle strobe: frame started with holding register empty
//   underrun_count  saturating underrun count (I2S_UNDERRUN_CNT_EN only)
//   I2S_BCLK        serial bit clock
//   I2S_WCLK        word / frame clock
//   I2S_DATA        serial data, MSB first
// ---------------------------------------------------------------------------
module i2s_tdm_transmitter #(
    parameter int unsigned BITS      = 16,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned BCLK_DIV  = 4,
    parameter int unsigned MODE      = 0,
    parameter int unsigned INV_BCLK  = 0
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic [CHANNELS*BITS-1:0]   sample_data,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       frame_pulse,
    output logic                       underrun,
`ifdef I2S_UNDERRUN_CNT_EN
    output logic [15:0]                underrun_count,
`endif
    output logic                       I2S_BCLK,
    output logic                       I2S_WCLK,
    output logic                       I2S_DATA
);

    localparam int unsigned FRAME_W = CHANNELS * BITS;
    localparam int unsigned DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BIT_W   = $clog2(SLOT_BITS);
    localparam int unsigned SLOT_W  = $clog2(CHANNELS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(CHANNELS / 2);

    // Unknown MODE values fall through to left-justified.
    localparam logic MODE_I2S = (MODE == 0);
    localparam logic MODE_RJ  = (MODE == 2);
    localparam logic BCLK_INV = (INV_BCLK != 0);

    // ---------------- state ----------------
    logic [DIV_W-1:0]   div_cnt_q,  div_cnt_d;
    logic               bclk_q,     bclk_d;
    logic               bclk_pin_q, bclk_pin_d;
    logic               run_q,      run_d;
    logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;

    logic [FRAME_W-1:0] hold_q,      hold_d;
    logic               hold_full_q, hold_full_d;
    logic [FRAME_W-1:0] frame_q,     frame_d;
    logic               ready_q,     ready_d;
    logic               fpulse_q,    fpulse_d;
    logic               urun_q,      urun_d;

    logic               wclk_q,  wclk_d;
    logic               lj_q,    lj_d;
    logic               data_q,  data_d;

`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0]        ucnt_q,  ucnt_d;
`endif

    // ---------------- combinational strobes ----------------
    logic               term_cnt;
    logic               fall_tick;
    logic               frame_start;
    logic               accept;

    logic [BITS-1:0]    chan_w [CHANNELS];
    logic [BITS-1:0]    chan_word;
    logic [BITS-1:0]    lj_shift;
    logic [BITS-1:0]    rj_shift;

    // Bit-clock divider and frame position counters.
    always_comb begin
        div_cnt_d  = div_cnt_q + 1'b1;
        bclk_d     = bclk_q;
        run_d      = run_q;
        bit_cnt_d  = bit_cnt_q;
        slot_cnt_d = slot_cnt_q;

        term_cnt  = (div_cnt_q == DIV_LAST);
        fall_tick = term_cnt && bclk_q;

        if (term_cnt) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end

        if (fall_tick) begin
            run_d = 1'b1;
            if (!run_q) begin
                // First falling edge after reset lands on bit 0, slot 0.
                bit_cnt_d  = '0;
                slot_cnt_d = '0;
            end else if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d  = '0;
                slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + 1'b1;
            end else begin
                bit_cnt_d  = bit_cnt_q + 1'b1;
            end
        end

        frame_start = fall_tick && (bit_cnt_d == '0) && (slot_cnt_d == '0);
        bclk_pin_d  = bclk_d ^ BCLK_INV;
    end

    // Handshake, holding register and frame buffer transfer.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        frame_d     = frame_q;
        fpulse_d    = 1'b0;
        urun_d      = 1'b0;

        accept = sample_valid && ready_q;

        // Accept and a full-holding transfer are exclusive since ready_q=0
        // whenever the holding register is full.
        if (accept) begin
            hold_d      = sample_data;
            hold_full_d = 1'b1;
        end

        if (frame_start) begin
            if (hold_full_q) begin
                frame_d     = hold_q;
                hold_d      = '0;
                hold_full_d = 1'b0;
                fpulse_d    = 1'b1;
            end else begin
                frame_d = '0;
                urun_d  = 1'b1;
            end
        end

        ready_d = ~hold_full_d;
    end

`ifdef I2S_UNDERRUN_CNT_EN
    // Saturating underrun counter.
    always_comb begin
        ucnt_d = ucnt_q;
        if (urun_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end
`endif

    // Split the next frame buffer into per-channel words.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign chan_w[g] = frame_d[g*BITS +: BITS];
    end

    // Serial word clock and data for the position being entered.
    always_comb begin
        wclk_d = wclk_q;
        lj_d   = lj_q;
        data_d = data_q;

        chan_word = chan_w[slot_cnt_d];
        // Shifting past the word width yields zero, which gives the
        // zero padding of both justifications without extra compares.
        lj_shift  = chan_word << bit_cnt_d;
        rj_shift  = chan_word >> (BIT_LAST - bit_cnt_d);

        if (fall_tick) begin
            wclk_d = (slot_cnt_d >= SLOT_HALF);
            lj_d   = lj_shift[BITS-1];
            if (MODE_I2S) begin
                data_d = lj_q;
            end else if (MODE_RJ) begin
                data_d = rj_shift[0];
            end else begin
                data_d = lj_shift[BITS-1];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            bclk_pin_q  <= BCLK_INV;
            run_q       <= 1'b0;
            bit_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            frame_q     <= '0;
            ready_q     <= 1'b1;
            fpulse_q    <= 1'b0;
            urun_q      <= 1'b0;
            wclk_q      <= 1'b0;
            lj_q        <= 1'b0;
            data_q      <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bclk_q      <= bclk_d;
            bclk_pin_q  <= bclk_pin_d;
            run_q       <= run_d;
            bit_cnt_q   <= bit_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            frame_q     <= frame_d;
            ready_q     <= ready_d;
            fpulse_q    <= fpulse_d;
            urun_q      <= urun_d;
            wclk_q      <= wclk_d;
            lj_q        <= lj_d;
            data_q      <= data_d;
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`endif

    assign sample_ready = ready_q;
    assign frame_pulse  = fpulse_q;
    assign underrun     = urun_q;
    assign I2S_BCLK     = bclk_pin_q;
    assign I2S_WCLK     = wclk_q;
    assign I2S_DATA     = data_q;

endmodule

// File: tb/tb_i2s_tdm_transmitter.sv
// ---------------------------------------------------------------------------
// tb_i2s_tdm_transmitter
//   Three stereo instances (MODE 0/1/2, BCLK_DIV=2) share one stimulus and are
//   checked every cycle against a frame-position reference model; a directed
//   table checks whole serialised frames; a 4-channel instance covers the
//   asynchronous mid-frame reset.
// ---------------------------------------------------------------------------
module tb_i2s_tdm_transmitter;

    localparam int unsigned NB         = 16;
    localparam int unsigned SB         = 32;
    localparam int unsigned NCH        = 2;
    localparam int unsigned DIV        = 2;
    localparam int unsigned FRAME_BITS = SB * NCH;
    localparam int unsigned BCLK_CYC   = 2 * DIV;
    localparam int unsigned FRAME_CYC  = FRAME_BITS * BCLK_CYC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst    = 1'b1;
    logic [NCH*NB-1:0]   sdata  = '0;
    logic                svalid = 1'b0;
    logic [2:0]          rdy, fp, ur, bclk, wclk, dat;
`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0]         ucnt [3];
`endif

    // Index m = MODE: 0 I2S, 1 left-justified, 2 right-justified.
    for (genvar m = 0; m < 3; m++) begin : g_dut
        i2s_tdm_transmitter #(
            .BITS(NB), .SLOT_BITS(SB), .CHANNELS(NCH),
            .BCLK_DIV(DIV), .MODE(m), .INV_BCLK(0)
        ) u_dut (
            .clk_in        (clk),
            .reset         (rst),
            .sample_data   (sdata),
            .sample_valid  (svalid),
            .sample_ready  (rdy[m]),
            .frame_pulse   (fp[m]),
            .underrun      (ur[m]),
`ifdef I2S_UNDERRUN_CNT_EN
            .underrun_count(ucnt[m]),
`endif
            .I2S_BCLK      (bclk[m]),
            .I2S_WCLK      (wclk[m]),
            .I2S_DATA      (dat[m])
        );
    end

    logic        rst4    = 1'b1;
    logic [63:0] data4   = '0;
    logic        valid4  = 1'b0;
    logic        rdy4, fp4, ur4, bclk4, wclk4, dat4;
`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] ucnt4;
`endif

    i2s_tdm_transmitter #(
        .BITS(16), .SLOT_BITS(16), .CHANNELS(4),
        .BCLK_DIV(2), .MODE(1), .INV_BCLK(0)
    ) u_dut4 (
        .clk_in        (clk),
        .reset         (rst4),
        .sample_data   (data4),
        .sample_valid  (valid4),
        .sample_ready  (rdy4),
        .frame_pulse   (fp4),
        .underrun      (ur4),
`ifdef I2S_UNDERRUN_CNT_EN
        .underrun_count(ucnt4),
`endif
        .I2S_BCLK      (bclk4),
        .I2S_WCLK      (wclk4),
        .I2S_DATA      (dat4)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Position is pure arithmetic on the number of clk_in edges since reset:
    // falling BCLK edges happen every 2*DIV edges, the n-th one (from 0)
    // drives frame position n mod (SB*NCH).
    int unsigned m_e;
    logic        m_full;
    logic [31:0] m_hold;
    logic [15:0] m_frame [NCH];
    logic        m_bclk, m_wclk, m_lj, m_rj, m_i2s, m_ready, m_fp, m_ur;
    logic [15:0] m_ucnt;

    initial begin : model
        int unsigned n, p, s, b;
        logic acc;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_e = 0; m_full = 1'b0; m_hold = '0;
                m_frame[0] = '0; m_frame[1] = '0;
                m_bclk = 1'b0; m_wclk = 1'b0; m_lj = 1'b0; m_rj = 1'b0;
                m_i2s = 1'b0; m_ready = 1'b1; m_fp = 1'b0; m_ur = 1'b0;
                m_ucnt = '0;
            end else begin
                acc  = svalid && !m_full;
                m_e  = m_e + 1;
                m_bclk = 1'((m_e / DIV) % 2);
                m_fp = 1'b0;
                m_ur = 1'b0;
                if (m_e % BCLK_CYC == 0) begin
                    n = m_e / BCLK_CYC - 1;
                    p = n % FRAME_BITS;
                    s = p / SB;
                    b = p % SB;
                    if (p == 0) begin
                        if (m_full) begin
                            m_frame[0] = m_hold[15:0];
                            m_frame[1] = m_hold[31:16];
                            m_full = 1'b0;
                            m_fp   = 1'b1;
                        end else begin
                            m_frame[0] = '0;
                            m_frame[1] = '0;
                            m_ur = 1'b1;
                            if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
                        end
                    end
                    m_wclk = (s >= NCH / 2);
                    m_i2s  = m_lj;
                    m_lj   = (b < NB)      ? m_frame[s][NB-1-b] : 1'b0;
                    m_rj   = (b >= SB - NB) ? m_frame[s][SB-1-b] : 1'b0;
                end
                if (acc) begin
                    m_full = 1'b1;
                    m_hold = sdata;
                end
                m_ready = !m_full;
            end
        end
    end

    // Every-cycle comparison of the stereo instances against the model.
    initial begin : cycle_checker
        logic [17:0] got, exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                got = {bclk, wclk, dat, rdy, fp, ur};
                exp = {{3{m_bclk}}, {3{m_wclk}}, {m_rj, m_lj, m_i2s},
                       {3{m_ready}}, {3{m_fp}}, {3{m_ur}}};
                check("cycle_outputs", 64'(got), 64'(exp));
`ifdef I2S_UNDERRUN_CNT_EN
                check("cycle_ucnt", 64'({ucnt[0], ucnt[1], ucnt[2]}), 64'({3{m_ucnt}}));
`endif
            end
        end
    end

    // ---------------- directed frame table ----------------
    typedef struct {
        logic [15:0] l, r;
        logic [31:0] lj0, lj1, rj0, rj1, i0, i1;
    } vec_t;

    vec_t vt [4];

    initial begin : main
        logic [63:0] cap [3];
        logic [63:0] wcap;
        logic [3:0]  before4;
        int          found, cnt_ur, cnt_ones, cnt_acc, cnt_fp;
        logic [15:0] ucnt_before;

        vt[0] = '{16'hA5A5, 16'h3C3C, 32'hA5A5_0000, 32'h3C3C_0000,
                  32'h0000_A5A5, 32'h0000_3C3C, 32'h52D2_8000, 32'h1E1E_0000};
        vt[1] = '{16'hFFFF, 16'h0001, 32'hFFFF_0000, 32'h0001_0000,
                  32'h0000_FFFF, 32'h0000_0001, 32'h7FFF_8000, 32'h0000_8000};
        vt[2] = '{16'h8000, 16'h8001, 32'h8000_0000, 32'h8001_0000,
                  32'h0000_8000, 32'h0000_8001, 32'h4000_0000, 32'h4000_8000};
        vt[3] = '{16'h1234, 16'hFEDC, 32'h1234_0000, 32'hFEDC_0000,
                  32'h0000_1234, 32'h0000_FEDC, 32'h091A_0000, 32'h7F6E_0000};
        ucnt_before = '0;

        repeat (3) @(negedge clk);
        check("reset_state", 64'({bclk, wclk, dat, rdy, fp, ur}), 64'(18'b000_000_000_111_000_000));
        check("reset_state4", 64'({bclk4, wclk4, dat4, rdy4, fp4, ur4}), 64'(6'b000100));
        rst = 1'b0;

        // Whole-frame serialisation for each table entry.
        for (int i = 0; i < 4; i++) begin
            found = 0;
            for (int k = 0; k < 2 * FRAME_CYC; k++) begin
                if (rdy[1]) begin found = 1; break; end
                @(negedge clk);
            end
            check("ready_wait", 64'(found), 64'd1);
            sdata  = {vt[i].r, vt[i].l};
            svalid = 1'b1;
            @(negedge clk);
            svalid = 1'b0;
            sdata  = $urandom;
            found  = 0;
            for (int k = 0; k < 2 * FRAME_CYC; k++) begin
                if (fp[1]) begin found = 1; break; end
                @(negedge clk);
            end
            check("frame_pulse_wait", 64'(found), 64'd1);
            if (found == 0) continue;
            for (int k = 0; k < 64; k++) begin
                if (k != 0) repeat (BCLK_CYC) @(negedge clk);
                for (int m = 0; m < 3; m++) cap[m] = {cap[m][62:0], dat[m]};
                wcap = {wcap[62:0], wclk[1]};
            end
            check("lj_word", cap[1], {vt[i].lj0, vt[i].lj1});
            check("rj_word", cap[2], {vt[i].rj0, vt[i].rj1});
            check("i2s_word", cap[0], {vt[i].i0, vt[i].i1});
            check("wclk_pattern", wcap, 64'h0000_0000_FFFF_FFFF);
        end

        // Three frames of underrun: three pulses, silent data.
        svalid = 1'b0;
`ifdef I2S_UNDERRUN_CNT_EN
        ucnt_before = ucnt[1];
`endif
        cnt_ur = 0;
        cnt_ones = 0;
        for (int k = 0; k < 3 * FRAME_CYC; k++) begin
            @(negedge clk);
            if (ur[1]) cnt_ur++;
            if (|dat) cnt_ones++;
        end
        check("underrun_pulses", 64'(cnt_ur), 64'd3);
        check("underrun_silent", 64'(cnt_ones), 64'd0);
`ifdef I2S_UNDERRUN_CNT_EN
        check("underrun_count_delta", 64'(ucnt[1] - ucnt_before), 64'd3);
`endif

        // Randomised traffic, checked every cycle by the model.
        for (int k = 0; k < 3000; k++) begin
            svalid = ($urandom_range(0, 2) == 0);
            sdata  = $urandom;
            @(negedge clk);
        end

        // Continuous valid: one accept and one frame pulse per frame.
        svalid = 1'b1;
        found  = 0;
        for (int k = 0; k < 2 * FRAME_CYC; k++) begin
            @(negedge clk);
            sdata = $urandom;
            if (fp[1] || ur[1]) begin found = 1; break; end
        end
        check("stream_sync", 64'(found), 64'd1);
        cnt_acc = 0;
        cnt_fp  = 0;
        for (int k = 0; k < 4 * FRAME_CYC; k++) begin
            if (k != 0) @(negedge clk);
            if (rdy[1]) cnt_acc++;
            if (fp[1]) cnt_fp++;
            sdata = $urandom;
        end
        check("stream_accepts", 64'(cnt_acc), 64'd4);
        check("stream_frames", 64'(cnt_fp), 64'd4);
        svalid = 1'b0;

        // Four-channel instance: asynchronous reset in the middle of slot 2.
        data4  = '1;
        valid4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        found = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (wclk4) begin found = k; break; end
        end
        check("tdm_wclk_rise_edge", 64'(found), 64'd132);
        repeat (12) @(negedge clk);
        before4 = {dat4, rdy4, fp4, ur4};
        check("tdm_pre_reset", 64'(before4), 64'b1000);
        #3 rst4 = 1'b1;
        #1;
        check("tdm_async_reset", 64'({bclk4, wclk4, dat4, rdy4, fp4, ur4}), 64'(6'b000100));
        valid4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b0;
        found = 0;
        cnt_fp = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (fp4) cnt_fp++;
            if (ur4) begin found = k; break; end
        end
        check("tdm_first_underrun_edge", 64'(found), 64'd4);
        check("tdm_no_frame_pulse", 64'(cnt_fp), 64'd0);
`ifdef I2S_UNDERRUN_CNT_EN
        check("tdm_ucnt_after_reset", 64'(ucnt4), 64'd1);
`endif

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
